// File: rtl/hazard_sched_pkg.sv
// Shared RISC-V opcode/funct definitions plus the hazard scheduler's NOP and state encoding.
package hazard_sched_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_CSR       = 7'b1110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [2:0] FNC_ADD_SUB = 3'b000;
    localparam logic [2:0] FNC_LW      = 3'b010;

    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
    localparam logic [31:0] NOP_INSN      = 32'h00000013;

    typedef enum logic [1:0] {
        HS_RUN     = 2'd0,
        HS_LD_BUB  = 2'd1,
        HS_MC_WAIT = 2'd2
    } hs_state_t;

endpackage

// File: rtl/hazard_sched_if.sv
// Core <-> hazard scheduler bundle: instruction words in, pipeline control out.
interface hazard_sched_if #(
    parameter int CNT_W = 32
);
    import hazard_sched_pkg::*;

    logic [31:0]      instruction_s1;
    logic [31:0]      instruction_s2;
    logic             br_taken;
    logic             mc_done;
    logic             stall_s1;
    logic             stall_s2;
    logic             bubble_s2;
    logic             flush_s1;
    logic             pc_sel;
    logic             mc_start;
    logic             wb_fwd_sel_1;
    logic             wb_fwd_sel_2;
    logic             mc_err;
    logic [CNT_W-1:0] stall_count;
    logic [31:0]      nop_insn;
    hs_state_t        state;

    // mc_start is a single-cycle request; mc_done is a single-cycle completion pulse that only counts while waiting.
    modport master (
        output instruction_s1, instruction_s2, br_taken, mc_done,
        input  stall_s1, stall_s2, bubble_s2, flush_s1, pc_sel, mc_start,
               wb_fwd_sel_1, wb_fwd_sel_2, mc_err, stall_count, nop_insn, state
    );

    modport slave (
        input  instruction_s1, instruction_s2, br_taken, mc_done,
        output stall_s1, stall_s2, bubble_s2, flush_s1, pc_sel, mc_start,
               wb_fwd_sel_1, wb_fwd_sel_2, mc_err, stall_count, nop_insn, state
    );

endinterface

// File: rtl/hazard_sched_decode.sv
// Combinational hazard decode of the s1/s2 instruction words.
module hazard_sched_decode
    import hazard_sched_pkg::*;
(
    input  logic [31:0] instruction_s1,
    input  logic [31:0] instruction_s2,
    input  logic        br_taken,
    output logic        ld2,
    output logic        use_rs1,
    output logic        use_rs2,
    output logic        mc2,
    output logic        redir
);
    logic [6:0] op1;
    logic [6:0] op2;
    logic [4:0] rd2;
    logic       reads1;
    logic       reads2;
    logic       unused_bits;

    assign op1 = instruction_s1[6:0];
    assign op2 = instruction_s2[6:0];
    assign rd2 = instruction_s2[11:7];

    always_comb begin
        reads1 = 1'b0;
        reads2 = 1'b0;
        case (op1)
            OPC_ARI_RTYPE, OPC_STORE, OPC_BRANCH: begin
                reads1 = 1'b1;
                reads2 = 1'b1;
            end
            OPC_ARI_ITYPE, OPC_LOAD, OPC_JALR, OPC_CSR: reads1 = 1'b1;
            default: ;
        endcase
    end

    // x0 destinations are filtered here, so the operand matches never need to.
    assign ld2     = (op2 == OPC_LOAD) && (rd2 != 5'd0);
    assign use_rs1 = reads1 && (instruction_s1[19:15] == rd2);
    assign use_rs2 = reads2 && (instruction_s1[24:20] == rd2);
    assign mc2     = (op2 == OPC_ARI_RTYPE) && (instruction_s2[31:25] == FUNCT7_MULDIV);
    assign redir   = br_taken || (op2 == OPC_JAL) || (op2 == OPC_JALR);

    assign unused_bits = ^{instruction_s1[31:25], instruction_s1[14:7], instruction_s2[24:12]};

endmodule

// File: rtl/hazard_sched.sv
// Hazard scheduler: load-use bubbles, multi-cycle execute stalls with timeout, branch flushes.
module hazard_sched #(
    parameter int          MC_MAX_CYCLES = 64,
    parameter int          CNT_W         = 32,
    parameter logic [31:0] NOP_INSN      = 32'h00000013
) (
    input logic           clk,
    input logic           rst,
    hazard_sched_if.slave bus
);
    import hazard_sched_pkg::*;

    localparam int TW = (MC_MAX_CYCLES > 2) ? $clog2(MC_MAX_CYCLES) : 1;

    hs_state_t        state;
    hs_state_t        state_nx;
    logic             ld2, use_rs1, use_rs2, mc2, redir;
    logic             ld_stall;
    logic             mc_timeout;
    logic [TW-1:0]    mc_timer;
    logic [1:0]       ld_match;
    logic [1:0]       fwd_q;
    logic             mc_err_q;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_s1, stall_s2, bubble_s2, flush_s1, pc_sel, mc_start;

    hazard_sched_decode u_decode (
        .instruction_s1 (bus.instruction_s1),
        .instruction_s2 (bus.instruction_s2),
        .br_taken       (bus.br_taken),
        .ld2            (ld2),
        .use_rs1        (use_rs1),
        .use_rs2        (use_rs2),
        .mc2            (mc2),
        .redir          (redir)
    );

    assign ld_stall   = ld2 && (use_rs1 || use_rs2);
    assign mc_timeout = (mc_timer == TW'(MC_MAX_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HS_RUN;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            HS_RUN: begin
                if (mc2)           state_nx = HS_MC_WAIT;
                else if (redir)    state_nx = HS_RUN;
                else if (ld_stall) state_nx = HS_LD_BUB;
            end
            HS_LD_BUB:  state_nx = HS_RUN;
            HS_MC_WAIT: if (bus.mc_done || mc_timeout) state_nx = HS_RUN;
            default:    state_nx = HS_RUN;
        endcase
    end

    // Gated by rst so a held mul in s2 cannot pulse mc_start while reset is asserted.
    always_comb begin
        stall_s1  = 1'b0;
        stall_s2  = 1'b0;
        bubble_s2 = 1'b0;
        flush_s1  = 1'b0;
        pc_sel    = 1'b0;
        mc_start  = 1'b0;
        if (rst) begin
            case (state)
                HS_RUN: begin
                    if (mc2) begin
                        mc_start = 1'b1;
                        stall_s1 = 1'b1;
                        stall_s2 = 1'b1;
                    end else if (redir) begin
                        pc_sel   = 1'b1;
                        flush_s1 = 1'b1;
                    end else if (ld_stall) begin
                        stall_s1  = 1'b1;
                        bubble_s2 = 1'b1;
                    end
                end
                HS_MC_WAIT: begin
                    stall_s1 = !(bus.mc_done || mc_timeout);
                    stall_s2 = !(bus.mc_done || mc_timeout);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_timer  <= '0;
            ld_match  <= 2'b00;
            fwd_q     <= 2'b00;
            mc_err_q  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            mc_timer <= (state == HS_MC_WAIT) ? mc_timer + 1'b1 : '0;
            if (bubble_s2) ld_match <= {use_rs2, use_rs1};
            // The consumer reaches s2 the cycle after the bubble state.
            fwd_q <= (state == HS_LD_BUB) ? ld_match : 2'b00;
            if (state == HS_MC_WAIT && mc_timeout && !bus.mc_done) mc_err_q <= 1'b1;
            if (stall_s1 && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.stall_s1     = stall_s1;
    assign bus.stall_s2     = stall_s2;
    assign bus.bubble_s2    = bubble_s2;
    assign bus.flush_s1     = flush_s1;
    assign bus.pc_sel       = pc_sel;
    assign bus.mc_start     = mc_start;
    assign bus.wb_fwd_sel_1 = fwd_q[0];
    assign bus.wb_fwd_sel_2 = fwd_q[1];
    assign bus.mc_err       = mc_err_q;
    assign bus.stall_count  = stall_cnt;
    assign bus.nop_insn     = NOP_INSN;
    assign bus.state        = state;

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed scenarios plus a randomized run against a cycle-indexed model.
module tb_hazard_sched;
    import hazard_sched_pkg::*;

    localparam int MC_MAX = 64;

    localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_BR   = 7'b1100011;
    localparam logic [6:0] T_JALR = 7'b1100111, T_JAL   = 7'b1101111, T_R    = 7'b0110011;
    localparam logic [6:0] T_I    = 7'b0010011, T_CSR   = 7'b1110011, T_LUI  = 7'b0110111;

    // Packed control view: {stall_s1, stall_s2, bubble_s2, flush_s1, pc_sel, mc_start, fwd1, fwd2}
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_LDST  = 8'b1010_0000;
    localparam logic [7:0] C_MC    = 8'b1100_0100;
    localparam logic [7:0] C_MCW   = 8'b1100_0000;
    localparam logic [7:0] C_REDIR = 8'b0001_1000;
    localparam logic [7:0] C_FWD1  = 8'b0000_0010;

    localparam logic [31:0] I_NOP  = 32'h00000013;
    localparam logic [31:0] I_LW5  = {12'd0, 5'd1, 3'b010, 5'd5, T_LOAD};
    localparam logic [31:0] I_LW0  = {12'd0, 5'd1, 3'b010, 5'd0, T_LOAD};
    localparam logic [31:0] I_ADD  = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, T_R};
    localparam logic [31:0] I_ADD0 = {7'd0, 5'd2, 5'd0, 3'b000, 5'd6, T_R};
    localparam logic [31:0] I_MUL  = {7'b0000001, 5'd5, 5'd4, 3'b000, 5'd3, T_R};
    localparam logic [31:0] I_BEQ  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, T_BR};
    localparam logic [31:0] I_JAL  = {20'd16, 5'd1, T_JAL};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic        exp_err = 1'b0;
    logic [7:0]  exp_q[$];

    hazard_sched_if #(.CNT_W(32)) bus ();

    hazard_sched #(.MC_MAX_CYCLES(MC_MAX), .CNT_W(32), .NOP_INSN(32'h00000013)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctrl_vec();
        return {bus.stall_s1, bus.stall_s2, bus.bubble_s2, bus.flush_s1,
                bus.pc_sel, bus.mc_start, bus.wb_fwd_sel_1, bus.wb_fwd_sel_2};
    endfunction

    task automatic set_in(input logic [31:0] s1, input logic [31:0] s2, input logic br, input logic done);
        bus.instruction_s1 = s1;
        bus.instruction_s2 = s2;
        bus.br_taken       = br;
        bus.mc_done        = done;
    endtask

    // Inputs change just after the rising edge; outputs are observed at the falling edge.
    task automatic drive(input logic [31:0] s1, input logic [31:0] s2, input logic br, input logic done);
        @(posedge clk);
        #1;
        set_in(s1, s2, br, done);
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(I_ADD, I_MUL, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (ctrl_vec() !== C_NONE) begin failures++; $display("FAIL reset_ctrl: got %b expected %b", ctrl_vec(), C_NONE); end
        checks++;
        if (bus.stall_count !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", bus.stall_count); end
        checks++;
        if (bus.mc_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.mc_err); end
        checks++;
        if (bus.state !== HS_RUN) begin failures++; $display("FAIL reset_state: got %0d expected %0d", bus.state, HS_RUN); end
        set_in(I_NOP, I_NOP, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_vec() !== C_NONE) begin failures++; $display("FAIL reset_release: got %b expected %b", ctrl_vec(), C_NONE); end
    endtask

    task automatic test_load_use();
        logic [7:0] want[4];
        logic [31:0] s1s[4];
        logic [31:0] s2s[4];
        want = '{C_LDST, C_NONE, C_FWD1, C_NONE};
        s1s  = '{I_ADD, I_ADD, I_NOP, I_NOP};
        s2s  = '{I_LW5, I_NOP, I_ADD, I_NOP};
        for (int i = 0; i < 4; i++) begin
            drive(s1s[i], s2s[i], 1'b0, 1'b0);
            checks++;
            if (ctrl_vec() !== want[i]) begin
                failures++;
                $display("FAIL load_use_c%0d: got %b expected %b", i, ctrl_vec(), want[i]);
            end
        end
        exp_cnt = exp_cnt + 1;
        checks++;
        if (bus.stall_count !== exp_cnt) begin failures++; $display("FAIL load_use_count: got %0d expected %0d", bus.stall_count, exp_cnt); end
    endtask

    task automatic test_x0_load();
        for (int i = 0; i < 2; i++) begin
            drive((i == 0) ? I_ADD0 : I_NOP, (i == 0) ? I_LW0 : I_ADD0, 1'b0, 1'b0);
            checks++;
            if (ctrl_vec() !== C_NONE) begin failures++; $display("FAIL x0_load_c%0d: got %b expected %b", i, ctrl_vec(), C_NONE); end
        end
        checks++;
        if (bus.stall_count !== exp_cnt) begin failures++; $display("FAIL x0_count: got %0d expected %0d", bus.stall_count, exp_cnt); end
    endtask

    task automatic test_flush();
        // Taken branch while the s1 instruction also consumes the s2 destination.
        drive(I_ADD, I_LW5, 1'b1, 1'b0);
        checks++;
        if (ctrl_vec() !== C_REDIR) begin failures++; $display("FAIL flush_over_load: got %b expected %b", ctrl_vec(), C_REDIR); end
        drive(I_ADD, I_BEQ, 1'b1, 1'b0);
        checks++;
        if (ctrl_vec() !== C_REDIR) begin failures++; $display("FAIL flush_beq: got %b expected %b", ctrl_vec(), C_REDIR); end
        drive(I_NOP, I_JAL, 1'b0, 1'b0);
        checks++;
        if (ctrl_vec() !== C_REDIR) begin failures++; $display("FAIL flush_jal: got %b expected %b", ctrl_vec(), C_REDIR); end
        drive(I_NOP, I_NOP, 1'b0, 1'b0);
        checks++;
        if (ctrl_vec() !== C_NONE) begin failures++; $display("FAIL flush_after: got %b expected %b", ctrl_vec(), C_NONE); end
        checks++;
        if (bus.stall_count !== exp_cnt) begin failures++; $display("FAIL flush_count: got %0d expected %0d", bus.stall_count, exp_cnt); end
    endtask

    task automatic test_mc_done();
        logic [7:0] want;
        for (int c = 0; c <= 11; c++) begin
            if (c == 0)       want = C_MC;
            else if (c < 10)  want = C_MCW;
            else              want = C_NONE;
            drive(I_ADD, (c <= 10) ? I_MUL : I_NOP, 1'b0, (c == 10));
            checks++;
            if (ctrl_vec() !== want) begin failures++; $display("FAIL mc_done_c%0d: got %b expected %b", c, ctrl_vec(), want); end
        end
        exp_cnt = exp_cnt + 10;
        checks++;
        if (bus.stall_count !== exp_cnt) begin failures++; $display("FAIL mc_done_count: got %0d expected %0d", bus.stall_count, exp_cnt); end
        checks++;
        if (bus.mc_err !== 1'b0) begin failures++; $display("FAIL mc_done_err: got %b expected 0", bus.mc_err); end
    endtask

    task automatic test_mc_timeout();
        logic [7:0] want;
        for (int c = 0; c <= MC_MAX; c++) begin
            want = (c == 0) ? C_MC : ((c < MC_MAX) ? C_MCW : C_NONE);
            drive(I_NOP, I_MUL, 1'b0, 1'b0);
            checks++;
            if (ctrl_vec() !== want) begin failures++; $display("FAIL mc_timeout_c%0d: got %b expected %b", c, ctrl_vec(), want); end
        end
        checks++;
        if (bus.mc_err !== 1'b0) begin failures++; $display("FAIL mc_err_early: got %b expected 0", bus.mc_err); end
        for (int c = 0; c < 4; c++) begin
            drive(I_NOP, I_NOP, 1'b0, (c == 1));
            checks++;
            if (bus.mc_err !== 1'b1) begin failures++; $display("FAIL mc_err_sticky_c%0d: got %b expected 1", c, bus.mc_err); end
        end
        exp_cnt = exp_cnt + MC_MAX;
        checks++;
        if (bus.stall_count !== exp_cnt) begin failures++; $display("FAIL mc_timeout_count: got %0d expected %0d", bus.stall_count, exp_cnt); end
    endtask

    task automatic test_reset_mid_mc();
        for (int c = 0; c <= 5; c++) drive(I_NOP, I_MUL, 1'b0, 1'b0);
        checks++;
        if (ctrl_vec() !== C_MCW) begin failures++; $display("FAIL mid_mc_pre: got %b expected %b", ctrl_vec(), C_MCW); end
        #2 rst = 1'b0;
        #1;
        exp_cnt = 32'd0;
        exp_err = 1'b0;
        checks++;
        if (ctrl_vec() !== C_NONE) begin failures++; $display("FAIL mid_mc_ctrl: got %b expected %b", ctrl_vec(), C_NONE); end
        checks++;
        if (bus.stall_count !== 32'd0) begin failures++; $display("FAIL mid_mc_count: got %0d expected 0", bus.stall_count); end
        checks++;
        if (bus.mc_err !== 1'b0) begin failures++; $display("FAIL mid_mc_err: got %b expected 0", bus.mc_err); end
        checks++;
        if (bus.state !== HS_RUN) begin failures++; $display("FAIL mid_mc_state: got %0d expected %0d", bus.state, HS_RUN); end
        @(negedge clk);
        checks++;
        if (bus.mc_start !== 1'b0) begin failures++; $display("FAIL mid_mc_in_reset: got %b expected 0", bus.mc_start); end
        set_in(I_NOP, I_NOP, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(I_NOP, I_NOP, 1'b0, (c == 0));
            checks++;
            if (ctrl_vec() !== C_NONE) begin failures++; $display("FAIL mid_mc_after_c%0d: got %b expected %b", c, ctrl_vec(), C_NONE); end
        end
    endtask

    function automatic logic reads_rs1(input logic [31:0] insn);
        return insn[6:0] inside {T_R, T_I, T_LOAD, T_STORE, T_BR, T_JALR, T_CSR};
    endfunction

    function automatic logic reads_rs2(input logic [31:0] insn);
        return insn[6:0] inside {T_R, T_STORE, T_BR};
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [4:0] rd, r1, r2;
        rd = 5'($urandom_range(0, 3));
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 10))
            0:       return {7'd0, r2, r1, 3'b000, rd, T_R};
            1:       return {7'b0000001, r2, r1, 3'b000, rd, T_R};
            2:       return {12'd5, r1, 3'b000, rd, T_I};
            3, 4:    return {12'd0, r1, 3'b010, rd, T_LOAD};
            5:       return {7'd0, r2, r1, 3'b010, 5'd0, T_STORE};
            6:       return {7'd0, r2, r1, 3'b000, 5'd0, T_BR};
            7:       return {20'd8, rd, T_JAL};
            8:       return {12'd0, r1, 3'b000, rd, T_JALR};
            9:       return {20'h1, rd, T_LUI};
            default: return {12'h300, r1, 3'b001, rd, T_CSR};
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] s1, s2;
        logic        br, done, m1, m2, timeout;
        logic [7:0]  exp, got;
        logic [1:0]  fwd_at[int];
        bit          in_mc = 1'b0;
        int          mc_begin = 0;
        int          quiet_t = -1;
        for (int t = 0; t < 1500; t++) begin
            s1   = rand_insn();
            s2   = rand_insn();
            br   = (s2[6:0] == T_BR) && ($urandom_range(0, 1) == 1);
            done = ($urandom_range(0, 9) == 0);
            drive(s1, s2, br, done);
            exp = C_NONE;
            timeout = 1'b0;
            if (fwd_at.exists(t)) begin
                exp[1:0] = fwd_at[t];
                fwd_at.delete(t);
            end
            if (in_mc) begin
                if (done) in_mc = 1'b0;
                else if (t - mc_begin == MC_MAX) begin in_mc = 1'b0; timeout = 1'b1; end
                else exp = exp | C_MCW;
            end else if (t != quiet_t) begin
                m1 = reads_rs1(s1) && (s1[19:15] == s2[11:7]);
                m2 = reads_rs2(s1) && (s1[24:20] == s2[11:7]);
                if (s2[6:0] == T_R && s2[31:25] == 7'b0000001) begin
                    exp = exp | C_MC;
                    in_mc = 1'b1;
                    mc_begin = t;
                end else if (br || s2[6:0] == T_JAL || s2[6:0] == T_JALR) begin
                    exp = exp | C_REDIR;
                end else if (s2[6:0] == T_LOAD && s2[11:7] != 5'd0 && (m1 || m2)) begin
                    exp = exp | C_LDST;
                    quiet_t = t + 1;
                    fwd_at[t + 2] = {m1, m2};
                end
            end
            exp_q.push_back(exp);
            got = ctrl_vec();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin failures++; $display("FAIL rand_ctrl t=%0d: got %b expected %b", t, got, exp); end
            checks++;
            if (bus.stall_count !== exp_cnt) begin failures++; $display("FAIL rand_count t=%0d: got %0d expected %0d", t, bus.stall_count, exp_cnt); end
            checks++;
            if (bus.mc_err !== exp_err) begin failures++; $display("FAIL rand_err t=%0d: got %b expected %b", t, bus.mc_err, exp_err); end
            if (exp[7]) exp_cnt = exp_cnt + 1;
            if (timeout) exp_err = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_load();
        test_flush();
        test_mc_done();
        test_mc_timeout();
        test_reset_mid_mc();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
